// File: rtl/tone_pkg.sv
// Shared tables, FSM encoding and half-period arithmetic for the tone player.
package tone_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_LOAD = 2'd1;
   localparam state_t S_PLAY = 2'd2;
   localparam state_t S_GAP  = 2'd3;

   localparam int unsigned BASE_W = 11;

   function automatic logic [10:0] preset_lut(input logic [3:0] inx);
      logic [10:0] p;
      case (inx)
         4'd0:    p = 11'h7FF;
         4'd1:    p = 11'h305;
         4'd2:    p = 11'h390;
         4'd3:    p = 11'h40C;
         4'd4:    p = 11'h45C;
         4'd5:    p = 11'h4AD;
         4'd6:    p = 11'h50A;
         4'd7:    p = 11'h55C;
         4'd8:    p = 11'h582;
         4'd9:    p = 11'h5C8;
         4'd10:   p = 11'h606;
         4'd11:   p = 11'h640;
         4'd12:   p = 11'h656;
         4'd13:   p = 11'h684;
         4'd14:   p = 11'h69A;
         default: p = 11'h6C0;
      endcase
      return p;
   endfunction

   // 0 is a rest, 1..7 low octave, 8..14 repeat 1..7, 15 wraps to 1.
   function automatic logic [3:0] code_lut(input logic [3:0] inx);
      logic [3:0] c;
      if (inx == 4'd0)       c = 4'd0;
      else if (inx < 4'd8)   c = inx;
      else if (inx == 4'd15) c = 4'd1;
      else                   c = inx - 4'd7;
      return c;
   endfunction

   function automatic logic [31:0] calc_half_period(input logic [31:0]  preset,
                                                    input logic [7:0]   oct,
                                                    input int unsigned  div_w);
      logic [32:0] n0;
      logic [32:0] n;
      n0 = (33'd1 << div_w) - {1'b0, preset};
      n  = n0 >> oct;
      if (n == 33'd0) n = 33'd1;
      return n[31:0];
   endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note-command handshake between the score sequencer and the tone player.
interface tone_player_if #(
   parameter int unsigned DUR_W = 4,
   parameter int unsigned OCT_W = 2
);
   logic             valid;
   logic             ready;
   logic [3:0]       inx;
   logic [DUR_W-1:0] dur;
   logic [OCT_W-1:0] oct;

   modport master (output valid, inx, dur, oct, input ready);
   modport slave  (input valid, inx, dur, oct, output ready);
endinterface

// File: rtl/tone_div.sv
// Reload divider: toggles the speaker every i_n enabled cycles, cleared to silence.
module tone_div #(
   parameter int unsigned DIV_W = 11
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_n,
   output logic             o_spk
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_spk;
   logic             w_wrap;

   assign w_wrap = (r_cnt == i_n - DIV_W'(1));
   assign o_spk  = r_spk;

   // Clear wins over a wrap so end-of-note always silences the output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_spk <= 1'b0;
      end else if (i_clr) begin
         r_cnt <= '0;
         r_spk <= 1'b0;
      end else if (i_en) begin
         if (w_wrap) begin
            r_cnt <= '0;
            r_spk <= ~r_spk;
         end else begin
            r_cnt <= r_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/tone_player.sv
// Note player: captures a command, looks up its preset, plays it for DUR beats.
module tone_player
   import tone_pkg::*;
#(
   parameter int unsigned DIV_W  = 11,
   parameter int unsigned DUR_W  = 4,
   parameter int unsigned OCT_W  = 2,
   parameter int unsigned GAP_EN = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_tick,
   tone_player_if.slave     io_cmd,
   output logic             o_spk,
   output logic [DIV_W-1:0] o_to,
   output logic [3:0]       o_code,
   output logic             o_h,
   output logic             o_done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_inx;
   logic [DUR_W-1:0] r_dur;
   logic [OCT_W-1:0] r_oct;
   logic [DUR_W-1:0] r_beats;
   logic [DIV_W-1:0] r_to;
   logic [3:0]       r_code;
   logic             r_h;
   logic [DIV_W-1:0] r_n;
   logic             r_done;

   logic             w_accept;
   logic             w_end;
   logic             w_done_nxt;
   logic [DUR_W-1:0] w_dur_eff;
   logic [DIV_W-1:0] w_to;
   logic             w_div_clr;
   logic             w_div_en;

   // READY stays low through the DONE cycle so it rises one cycle later.
   assign io_cmd.ready = (r_state == S_IDLE) && !r_done;
   assign w_accept     = io_cmd.valid && io_cmd.ready;

   assign w_dur_eff  = (r_dur == '0) ? DUR_W'(1) : r_dur;
   assign w_end      = (r_state == S_PLAY) && i_tick && (r_beats == w_dur_eff - DUR_W'(1));
   assign w_done_nxt = (w_end && (GAP_EN == 0)) || ((r_state == S_GAP) && i_tick);
   assign w_to       = DIV_W'(preset_lut(r_inx)) << (DIV_W - BASE_W);

   assign w_div_clr = (r_state != S_PLAY) || w_end;
   assign w_div_en  = (r_state == S_PLAY) && (r_inx != 4'd0);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_PLAY;
         S_PLAY:  if (w_end) w_state_nxt = (GAP_EN != 0) ? S_GAP : S_IDLE;
         S_GAP:   if (i_tick) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_inx   <= '0;
         r_dur   <= '0;
         r_oct   <= '0;
         r_beats <= '0;
         r_to    <= '1;
         r_code  <= '0;
         r_h     <= 1'b0;
         r_n     <= DIV_W'(1);
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_inx <= io_cmd.inx;
            r_dur <= io_cmd.dur;
            r_oct <= io_cmd.oct;
         end
         if (r_state == S_LOAD) begin
            r_to    <= w_to;
            r_code  <= code_lut(r_inx);
            r_h     <= r_inx[3] | (r_oct != '0);
            r_n     <= DIV_W'(calc_half_period(32'(w_to), 8'(r_oct), DIV_W));
            r_beats <= '0;
         end else if ((r_state == S_PLAY) && i_tick) begin
            r_beats <= r_beats + DUR_W'(1);
         end
      end
   end

   tone_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_div_clr),
      .i_en    (w_div_en),
      .i_n     (r_n),
      .o_spk   (o_spk)
   );

   assign o_to   = r_to;
   assign o_code = r_code;
   assign o_h    = r_h;
   assign o_done = r_done;

endmodule
